wr_port_arbiter: RTL and testbench

//  Shares the register-file write port between three write-back requesters: microcode dest (MUX3D path),
//  RG2 path and TR path. Arbitrates, registers the winning dest/data, drives the MUX3S-style source select
//  and a decoded one-hot write-enable vector. Broadcast (dest 31) is sequenced over one or two cycles.

---
 rtl/wr_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_wr_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wr_port_arbiter.sv
// Register-file write-port arbiter: picks one of three write-back requesters,
// registers its dest/data, drives the source select and the decoded one-hot
// write enables. A broadcast (dest 31) runs in one cycle or is split in two.
module wr_port_arbiter #(
  parameter int unsigned DW          = 16,
  parameter bit          MICRO_PRIO  = 1'b1,
  parameter bit          BCAST_SPLIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [4:0]    dest0,
  input  logic [4:0]    dest1,
  input  logic [4:0]    dest2,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [2:0]    gnt,
  output logic [1:0]    wr_sel,
  output logic [DW-1:0] wr_data,
  output logic [19:0]   wr_en,
  output logic          bad_dest,
  output logic          busy
);

  localparam int unsigned NREQ  = 3;
  localparam int unsigned ENW   = 20;
  localparam int unsigned DESTW = 5;

  localparam logic [DESTW-1:0] DEST_BCAST = 5'd31;
  localparam logic [ENW-1:0]   EN_ALL     = 20'hFFFFF;
  localparam logic [ENW-1:0]   EN_LOW     = 20'h03FFF;
  localparam logic [ENW-1:0]   EN_HIGH    = 20'hFC000;

  typedef enum logic {ARB, BCAST2} state_t;

  state_t            state, state_n;
  logic [1:0]        ptr, ptr_n;

  logic [NREQ-1:0]   elig, rr_elig;
  logic              win_vld, rr_hit;
  logic [1:0]        win;
  logic [2:0]        idx;
  logic [DESTW-1:0]  win_dest;
  logic [DW-1:0]     win_data;
  logic [ENW-1:0]    dec_en;
  logic              dec_vld;

  logic [2:0]        gnt_n;
  logic [1:0]        sel_n;
  logic [DW-1:0]     data_n;
  logic [ENW-1:0]    en_n;
  logic              bad_n, busy_n;

  // Winner selection: requester granted this cycle is masked out; optional micro priority, else round-robin from ptr
  always_comb begin
    elig    = req & ~gnt;
    rr_elig = MICRO_PRIO ? (elig & 3'b110) : elig;
    win_vld = 1'b0;
    rr_hit  = 1'b0;
    win     = 2'd0;
    idx     = 3'd0;
    if (MICRO_PRIO && elig[0]) begin
      win_vld = 1'b1;
      win     = 2'd0;
    end else begin
      for (int k = 0; k < int'(NREQ); k++) begin
        idx = 3'(ptr) + 3'(k);
        if (idx >= 3'd3) idx = idx - 3'd3;
        if (!win_vld && rr_elig[idx[1:0]]) begin
          win_vld = 1'b1;
          rr_hit  = 1'b1;
          win     = idx[1:0];
        end
      end
    end
  end

  // Winner's dest/data mux and destination decode
  always_comb begin
    win_dest = dest0;
    win_data = data0;
    case (win)
      2'd1:    begin win_dest = dest1; win_data = data1; end
      2'd2:    begin win_dest = dest2; win_data = data2; end
      default: begin win_dest = dest0; win_data = data0; end
    endcase
    dec_en  = '0;
    dec_vld = 1'b0;
    if (win_dest >= 5'd1 && win_dest <= 5'd18) begin
      dec_en  = ENW'(1) << (win_dest - 5'd1);
      dec_vld = 1'b1;
    end else if (win_dest == 5'd21) begin
      dec_en  = ENW'(1) << 18;
      dec_vld = 1'b1;
    end else if (win_dest == 5'd22) begin
      dec_en  = ENW'(1) << 19;
      dec_vld = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = '0;
    sel_n   = '0;
    data_n  = '0;
    en_n    = '0;
    bad_n   = 1'b0;
    busy_n  = 1'b0;
    case (state)
      ARB: begin
        if (win_vld) begin
          if (rr_hit) ptr_n = (win == 2'd2) ? 2'd0 : win + 2'd1;
          sel_n  = win + 2'd1;
          data_n = win_data;
          if (win_dest == DEST_BCAST) begin
            if (BCAST_SPLIT) begin
              en_n    = EN_LOW;
              busy_n  = 1'b1;
              state_n = BCAST2;
            end else begin
              en_n  = EN_ALL;
              gnt_n = 3'b001 << win;
            end
          end else if (dec_vld) begin
            en_n  = dec_en;
            gnt_n = 3'b001 << win;
          end else begin
            bad_n = 1'b1;
            gnt_n = 3'b001 << win;
          end
        end
      end
      BCAST2: begin
        sel_n   = wr_sel;
        data_n  = wr_data;
        en_n    = EN_HIGH;
        gnt_n   = 3'b001 << (wr_sel - 2'd1);
        state_n = ARB;
      end
      default: state_n = ARB;
    endcase
  end

  // State and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= 2'd1;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      wr_sel   <= '0;
      wr_data  <= '0;
      wr_en    <= '0;
      bad_dest <= 1'b0;
      busy     <= 1'b0;
    end else begin
      gnt      <= gnt_n;
      wr_sel   <= sel_n;
      wr_data  <= data_n;
      wr_en    <= en_n;
      bad_dest <= bad_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Bench for wr_port_arbiter: two instances (micro-priority + split broadcast,
// and round-robin + single-cycle broadcast) share stimulus; expected outputs
// are queued when inputs are driven and compared after the next clock edge.
module tb_wr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [4:0]  dest0, dest1, dest2;
  logic [15:0] data0, data1, data2;

  logic [2:0]  gnt_a, gnt_b;
  logic [1:0]  sel_a, sel_b;
  logic [15:0] wdata_a, wdata_b;
  logic [19:0] en_a, en_b;
  logic        bad_a, bad_b, busy_a, busy_b;

  typedef struct packed {
    logic        which;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [19:0] en;
    logic        bad;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  logic which;
  int   n_checks = 0;
  int   n_err    = 0;

  wr_port_arbiter #(.DW(16), .MICRO_PRIO(1'b1), .BCAST_SPLIT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .dest0(dest0), .dest1(dest1), .dest2(dest2),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt_a), .wr_sel(sel_a), .wr_data(wdata_a), .wr_en(en_a),
    .bad_dest(bad_a), .busy(busy_a)
  );

  wr_port_arbiter #(.DW(16), .MICRO_PRIO(1'b0), .BCAST_SPLIT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .dest0(dest0), .dest1(dest1), .dest2(dest2),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt_b), .wr_sel(sel_b), .wr_data(wdata_b), .wr_en(en_b),
    .bad_dest(bad_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input logic rs, input logic [2:0] rq,
                      input logic [2:0] g, input logic [1:0] s, input logic [15:0] d,
                      input logic [19:0] e, input logic b, input logic bz);
    exp_t x;
    @(negedge clk);
    rst = rs;
    req = rq;
    x.which = which;
    x.gnt   = g;
    x.sel   = s;
    x.data  = d;
    x.en    = e;
    x.bad   = b;
    x.busy  = bz;
    exp_q.push_back(x);
  endtask

  task automatic idle(input logic rs, input logic [2:0] rq);
    step(rs, rq, 3'b000, 2'd0, 16'h0, 20'h0, 1'b0, 1'b0);
  endtask

  // Scoreboard: compare selected instance against the queued expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      if (!x.which) begin
        check("a_gnt",  32'(gnt_a),   32'(x.gnt));
        check("a_sel",  32'(sel_a),   32'(x.sel));
        check("a_data", 32'(wdata_a), 32'(x.data));
        check("a_en",   32'(en_a),    32'(x.en));
        check("a_bad",  32'(bad_a),   32'(x.bad));
        check("a_busy", 32'(busy_a),  32'(x.busy));
      end else begin
        check("b_gnt",  32'(gnt_b),   32'(x.gnt));
        check("b_sel",  32'(sel_b),   32'(x.sel));
        check("b_data", 32'(wdata_b), 32'(x.data));
        check("b_en",   32'(en_b),    32'(x.en));
        check("b_bad",  32'(bad_b),   32'(x.bad));
        check("b_busy", 32'(busy_b),  32'(x.busy));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req   = 3'b000;
    which = 1'b0;
    dest0 = 5'd0; dest1 = 5'd0; dest2 = 5'd0;
    data0 = 16'h0; data1 = 16'h0; data2 = 16'h0;

    // reset state
    idle(1'b1, 3'b000);
    idle(1'b1, 3'b000);

    // single RG2 write to R5
    dest1 = 5'd5; data1 = 16'hA5A5;
    step(1'b0, 3'b010, 3'b010, 2'd2, 16'hA5A5, 20'h00010, 1'b0, 1'b0);
    idle(1'b0, 3'b010);
    idle(1'b0, 3'b000);

    // micro priority with all requesters held: 0,1,0,2
    idle(1'b1, 3'b000);
    dest0 = 5'd1; dest1 = 5'd2; dest2 = 5'd3;
    data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333;
    step(1'b0, 3'b111, 3'b001, 2'd1, 16'h1111, 20'h00001, 1'b0, 1'b0);
    step(1'b0, 3'b111, 3'b010, 2'd2, 16'h2222, 20'h00002, 1'b0, 1'b0);
    step(1'b0, 3'b111, 3'b001, 2'd1, 16'h1111, 20'h00001, 1'b0, 1'b0);
    step(1'b0, 3'b111, 3'b100, 2'd3, 16'h3333, 20'h00004, 1'b0, 1'b0);
    idle(1'b0, 3'b100);
    idle(1'b0, 3'b000);

    // split broadcast from TR path
    dest2 = 5'd31; data2 = 16'hBEEF;
    step(1'b0, 3'b100, 3'b000, 2'd3, 16'hBEEF, 20'h03FFF, 1'b0, 1'b1);
    step(1'b0, 3'b100, 3'b100, 2'd3, 16'hBEEF, 20'hFC000, 1'b0, 1'b0);
    idle(1'b0, 3'b100);
    idle(1'b0, 3'b000);

    // unmapped dest, then IR write
    dest0 = 5'd20; data0 = 16'h0BAD;
    step(1'b0, 3'b001, 3'b001, 2'd1, 16'h0BAD, 20'h00000, 1'b1, 1'b0);
    idle(1'b0, 3'b001);
    dest0 = 5'd22; data0 = 16'h1234;
    step(1'b0, 3'b001, 3'b001, 2'd1, 16'h1234, 20'h80000, 1'b0, 1'b0);
    idle(1'b0, 3'b001);
    idle(1'b0, 3'b000);

    // reset in first half of a split broadcast aborts it
    dest0 = 5'd31; data0 = 16'h5555;
    step(1'b0, 3'b001, 3'b000, 2'd1, 16'h5555, 20'h03FFF, 1'b0, 1'b1);
    idle(1'b1, 3'b001);
    idle(1'b0, 3'b000);
    dest1 = 5'd15; data1 = 16'h7777;
    step(1'b0, 3'b010, 3'b010, 2'd2, 16'h7777, 20'h04000, 1'b0, 1'b0);
    idle(1'b0, 3'b010);
    idle(1'b0, 3'b000);

    // round-robin instance: order 1,2,0,1,2,0 from reset
    which = 1'b1;
    idle(1'b1, 3'b000);
    dest0 = 5'd1; dest1 = 5'd2; dest2 = 5'd3;
    data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333;
    for (int r = 0; r < 2; r++) begin
      step(1'b0, 3'b111, 3'b010, 2'd2, 16'h2222, 20'h00002, 1'b0, 1'b0);
      step(1'b0, 3'b111, 3'b100, 2'd3, 16'h3333, 20'h00004, 1'b0, 1'b0);
      step(1'b0, 3'b111, 3'b001, 2'd1, 16'h1111, 20'h00001, 1'b0, 1'b0);
    end
    idle(1'b0, 3'b001);
    idle(1'b0, 3'b000);

    // single-cycle broadcast on the round-robin instance
    dest2 = 5'd31; data2 = 16'hABCD;
    step(1'b0, 3'b100, 3'b100, 2'd3, 16'hABCD, 20'hFFFFF, 1'b0, 1'b0);
    idle(1'b0, 3'b100);
    idle(1'b0, 3'b000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) check("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
